// File: rtl/fetch.sv
// Instruction fetch stage: owns the program counter, issues word-aligned
// requests to instruction memory (one outstanding at most), buffers returned
// words with their PC in a small FIFO and presents the head entry to the
// decoder. A redirect from execute flushes the FIFO and restarts fetch.
// Optional feature macro: FETCH_BYPASS_EN (forward a response straight to the
// decoder when the FIFO is empty).
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        enabled,
    output logic [31:0] pc_out,
    output logic [31:0] instr_raw
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [31:0]     fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic            fifo_empty_s;
    logic            room_s;
    logic            accept_s;
    logic            resp_wait_s;
    logic            bypass_s;
    logic            bypass_take_s;
    logic            push_s;
    logic            pop_s;

    assign fifo_empty_s = (count_q == {CW{1'b0}});
    // In REQ nothing is outstanding, so room only depends on FIFO occupancy.
    assign room_s       = (count_q < CW'(DEPTH));
    // Redirect and reset both suppress the request combinationally.
    assign imem_req     = (state_q == ST_REQ) && room_s && !redirect_valid && !rstn;
    assign imem_addr    = pc_q;
    assign accept_s     = imem_req && imem_ready;
    assign resp_wait_s  = (state_q == ST_WAIT) && imem_rvalid;

`ifdef FETCH_BYPASS_EN
    assign bypass_s      = resp_wait_s && fifo_empty_s && !redirect_valid && !rstn;
    assign bypass_take_s = bypass_s && dec_ready;
`else
    assign bypass_s      = 1'b0;
    assign bypass_take_s = 1'b0;
`endif

    // A bypassed response consumed by the decoder never touches the FIFO.
    assign push_s = resp_wait_s && !redirect_valid && !bypass_take_s;
    assign pop_s  = !fifo_empty_s && dec_ready && !redirect_valid;

    assign enabled   = !fifo_empty_s || bypass_s;
    assign pc_out    = bypass_s ? inflight_pc_q : fifo_pc_q[rd_ptr_q];
    assign instr_raw = bypass_s ? imem_rdata    : fifo_instr_q[rd_ptr_q];

    // Next-state, next-PC and in-flight PC selection; redirect has priority.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (accept_s) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end else begin
            pc_d = pc_q;
        end
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    state_d = ST_REQ;
                end else if (accept_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else if (redirect_valid) begin
                    state_d = ST_DISCARD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                // The awaited response ends discard even if another redirect
                // lands the same cycle; staying would wait forever.
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // FSM state, program counter and in-flight PC registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO.
    always_ff @(posedge clk) begin
        if (rstn || redirect_valid) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end else begin
            fifo_pc_q[wr_ptr_q]    <= fifo_pc_q[wr_ptr_q];
            fifo_instr_q[wr_ptr_q] <= fifo_instr_q[wr_ptr_q];
        end
    end

endmodule
